// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready select input,
// output-valid flag, selectable polarity and an auto-scan strobe mode.
//
// Ports:
//   clk, rst         clock (rising edge), async active-high reset
//   en               block enable; low forces IDLE
//   mode             0 = decode sel, 1 = scan outputs in turn
//   sel_valid/ready  select handshake; ready only in DECODE
//   sel              binary select
//   q                one-hot output, inverted when ACTIVE_LOW
//   q_valid          q carries an active code
//   scan_idx         index currently driven in SCAN
//   wrap             one-cycle pulse when scan_idx returns to 0
module onehot_decoder_seq #(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   q,
  output logic                  q_valid,
  output logic [SEL_W-1:0]      scan_idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
  localparam logic [OUT_W-1:0] Q_OFF = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state;
  logic [DW_W-1:0]   dwell;
  logic [SEL_W-1:0]  idx_nxt;

  // Polarity applied only here, at the value loaded into q.
  function automatic logic [OUT_W-1:0] drive(
    input logic [SEL_W-1:0] i
  );
    return (OUT_W'(1) << i) ^ Q_OFF;
  endfunction

  assign sel_ready = (state == DECODE);
  assign idx_nxt   = scan_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      q        <= Q_OFF;
      q_valid  <= 1'b0;
      scan_idx <= '0;
      dwell    <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        q        <= Q_OFF;
        q_valid  <= 1'b0;
        scan_idx <= '0;
        dwell    <= '0;
      end else if (mode && state != SCAN) begin
        // Scan entry shows index 0 immediately, no wrap.
        state    <= SCAN;
        q        <= drive('0);
        q_valid  <= 1'b1;
        scan_idx <= '0;
        dwell    <= '0;
      end else if (!mode && state != DECODE) begin
        // Decode starts blank until the first transfer.
        state    <= DECODE;
        q        <= Q_OFF;
        q_valid  <= 1'b0;
        scan_idx <= '0;
        dwell    <= '0;
      end else if (state == DECODE) begin
        if (sel_valid) begin
          q       <= drive(sel);
          q_valid <= 1'b1;
        end
      end else begin
        if (dwell == DW_LAST) begin
          dwell    <= '0;
          scan_idx <= idx_nxt;
          q        <= drive(idx_nxt);
          wrap     <= &scan_idx;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end
    end
  end

endmodule
